// File: rtl/vc_sram_1rw_arbiter_pkg.sv
// Shared constants and types for the two-port front end of the single-ported SRAM.
// The port index encoding is used by the arbiter, the in-flight stage and the response steering.
package vc_sram_1rw_arbiter_pkg;

  localparam int c_mem_sz    = 32;
  localparam int c_data_sz   = 32;
  localparam int c_addr_sz   = $clog2(c_mem_sz);
  localparam int c_num_bytes = (c_data_sz + 7) / 8;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
    logic  write;
  } inflight_t;

  function automatic port_e other_port(input port_e p);
    return (p == PORT0) ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/vc_sram_1rw_arbiter_if.sv
// One requester's request/response channel pair (val/rdy on both sides).
// The master modport is the client view, the slave modport is the arbiter view.
interface vc_sram_1rw_arbiter_if
  import vc_sram_1rw_arbiter_pkg::*;
#(
  parameter int p_mem_sz  = c_mem_sz,
  parameter int p_data_sz = c_data_sz
) ();

  localparam int c_addr_sz   = $clog2(p_mem_sz);
  localparam int c_num_bytes = (p_data_sz + 7) / 8;

  logic                   req_val;
  logic                   req_rdy;
  logic                   req_write;
  logic [c_addr_sz-1:0]   req_addr;
  logic [p_data_sz-1:0]   req_data;
  logic [c_num_bytes-1:0] req_byte_en;

  logic                   resp_val;
  logic                   resp_rdy;
  logic                   resp_write;
  logic [p_data_sz-1:0]   resp_data;

  modport master (
    output req_val, req_write, req_addr, req_data, req_byte_en, resp_rdy,
    input  req_rdy, resp_val, resp_write, resp_data
  );

  modport slave (
    input  req_val, req_write, req_addr, req_data, req_byte_en, resp_rdy,
    output req_rdy, resp_val, resp_write, resp_data
  );

endinterface

// File: rtl/vc_sram_1rw_arbiter_sram.sv
// Single-ported synchronous SRAM with per-byte write enables and registered read data.
// A write cycle returns the word's previous contents on read_data; contents are never reset.
module vc_SRAM_1rw #(
  parameter int p_mem_sz  = 32,
  parameter int p_data_sz = 32
) (
  input  logic                             clk,
  input  logic                             en,
  input  logic                             write_en,
  input  logic [$clog2(p_mem_sz)-1:0]      addr,
  input  logic [p_data_sz-1:0]             write_data,
  input  logic [(p_data_sz+7)/8-1:0]       byte_en,
  output logic [p_data_sz-1:0]             read_data
);

  logic [p_data_sz-1:0] mem [p_mem_sz];

  always_ff @(posedge clk) begin
    if (en) begin
      read_data <= mem[addr];
      if (write_en) begin
        for (int i = 0; i < p_data_sz; i++) begin
          if (byte_en[i/8]) mem[addr][i] <= write_data[i];
        end
      end
    end
  end

endmodule

// File: rtl/vc_sram_1rw_arbiter.sv
// Round-robin two-port front end for vc_SRAM_1rw: one access per cycle, per-port in-order
// responses, and a one-entry holding buffer per port so a stalled consumer never blocks the other.
module vc_sram_1rw_arbiter
  import vc_sram_1rw_arbiter_pkg::*;
#(
  parameter int p_mem_sz  = c_mem_sz,
  parameter int p_data_sz = c_data_sz
) (
  input  logic                    clk,
  input  logic                    reset_n,
  vc_sram_1rw_arbiter_if.slave    port0,
  vc_sram_1rw_arbiter_if.slave    port1
);

  localparam int c_addr_sz   = $clog2(p_mem_sz);
  localparam int c_num_bytes = (p_data_sz + 7) / 8;

  logic [1:0]             req_val, req_write, req_rdy, resp_rdy;
  logic [c_addr_sz-1:0]   req_addr [2];
  logic [p_data_sz-1:0]   req_data [2];
  logic [c_num_bytes-1:0] req_byte_en [2];
  logic [1:0]             resp_val, resp_write;
  logic [p_data_sz-1:0]   resp_data [2];

  inflight_t              inflight;
  port_e                  prio;
  port_e                  grant_port;
  logic                   grant_valid;
  logic [1:0]             inflight_here, eligible, want;
  logic [1:0]             buf_valid, buf_write;
  logic [p_data_sz-1:0]   buf_data [2];
  logic [p_data_sz-1:0]   sram_read_data;

  assign req_val        = {port1.req_val, port0.req_val};
  assign req_write      = {port1.req_write, port0.req_write};
  assign resp_rdy       = {port1.resp_rdy, port0.resp_rdy};
  assign req_addr[0]    = port0.req_addr;
  assign req_addr[1]    = port1.req_addr;
  assign req_data[0]    = port0.req_data;
  assign req_data[1]    = port1.req_data;
  assign req_byte_en[0] = port0.req_byte_en;
  assign req_byte_en[1] = port1.req_byte_en;

  assign port0.req_rdy    = req_rdy[0];
  assign port1.req_rdy    = req_rdy[1];
  assign port0.resp_val   = resp_val[0];
  assign port1.resp_val   = resp_val[1];
  assign port0.resp_write = resp_write[0];
  assign port1.resp_write = resp_write[1];
  assign port0.resp_data  = resp_data[0];
  assign port1.resp_data  = resp_data[1];

  // A port may issue when nothing of its own is waiting, or when whatever is waiting
  // (buffered or in flight) is being consumed this very cycle.
  assign inflight_here = {inflight.valid && (inflight.port == PORT1),
                          inflight.valid && (inflight.port == PORT0)};
  assign eligible      = resp_rdy | (~buf_valid & ~inflight_here);
  assign want          = eligible & req_val;

  always_comb begin
    grant_valid = 1'b0;
    grant_port  = prio;
    if (want[prio]) begin
      grant_valid = 1'b1;
      grant_port  = prio;
    end else if (want[other_port(prio)]) begin
      grant_valid = 1'b1;
      grant_port  = other_port(prio);
    end
  end

  always_comb begin
    req_rdy = 2'b00;
    if (grant_valid && reset_n) req_rdy[grant_port] = 1'b1;
  end

  vc_SRAM_1rw #(
    .p_mem_sz  (p_mem_sz),
    .p_data_sz (p_data_sz)
  ) sram (
    .clk        (clk),
    .en         (grant_valid && reset_n),
    .write_en   (req_write[grant_port]),
    .addr       (req_addr[grant_port]),
    .write_data (req_data[grant_port]),
    .byte_en    (req_byte_en[grant_port]),
    .read_data  (sram_read_data)
  );

  // A full buffer always takes precedence; it can never coexist with an in-flight access of the same port.
  always_comb begin
    resp_val     = buf_valid | inflight_here;
    resp_write   = 2'b00;
    resp_data[0] = '0;
    resp_data[1] = '0;
    for (int p = 0; p < 2; p++) begin
      if (buf_valid[p]) begin
        resp_write[p] = buf_write[p];
        resp_data[p]  = buf_data[p];
      end else if (inflight_here[p]) begin
        resp_write[p] = inflight.write;
        resp_data[p]  = inflight.write ? '0 : sram_read_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= '0;
      prio     <= PORT0;
    end else begin
      inflight.valid <= grant_valid;
      inflight.port  <= grant_port;
      inflight.write <= req_write[grant_port];
      if (grant_valid) prio <= other_port(grant_port);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid   <= 2'b00;
      buf_write   <= 2'b00;
      buf_data[0] <= '0;
      buf_data[1] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (buf_valid[p] && resp_rdy[p]) begin
          buf_valid[p] <= 1'b0;
        end else if (inflight_here[p] && !resp_rdy[p]) begin
          buf_valid[p] <= 1'b1;
          buf_write[p] <= inflight.write;
          buf_data[p]  <= resp_data[p];
        end
      end
    end
  end

endmodule
